// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment display front end.
package seven_seg_pkg;

    // Width of one BCD / hex digit nibble.
    localparam int DIGIT_W = 4;

    // Double-dabble correction: digits at or above this get +3 before each shift.
    localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

    // Nibble shown in every digit when a decimal result does not fit.
    localparam logic [DIGIT_W-1:0] OVF_FILL = 4'hF;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble step over an N-digit BCD accumulator
// concatenated with the binary shift register: add-3 per digit, then shift
// the whole {bcd, shift} vector left by one. The bit leaving the top digit
// is reported as carry_out so the caller can flag overflow.
module bcd_dabble_step
    import seven_seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DATA_W = 16
) (
    input  logic [DIGITS*DIGIT_W-1:0] bcd_in,
    input  logic [DATA_W-1:0]         shift_in,
    output logic [DIGITS*DIGIT_W-1:0] bcd_out,
    output logic [DATA_W-1:0]         shift_out,
    output logic                      carry_out
);

    logic [DIGITS*DIGIT_W-1:0] adj;

    // Per-digit add-3 (4-bit, no inter-digit carry) followed by a 1-bit left shift.
    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*DIGIT_W +: DIGIT_W] >= ADD3_THRESH) begin
                adj[i*DIGIT_W +: DIGIT_W] = bcd_in[i*DIGIT_W +: DIGIT_W] + 4'd3;
            end
        end
        {carry_out, bcd_out, shift_out} = {adj, shift_in, 1'b0};
    end

endmodule

// File: rtl/bcd_display_formatter.sv
// Binary to display-digit formatter feeding the seven-segment controller.
// Decimal mode runs a bit-serial double-dabble (one input bit per clock);
// hex mode passes the captured value straight through. All outputs are
// registered and only change on the commit edge.
// Optional feature macro: BCD_DISPLAY_FORMATTER_LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits are blanked via out_mask (digit 0 never)
//   undefined -> out_mask stays all-zero, every digit lit
module bcd_display_formatter
    import seven_seg_pkg::*;
#(
    parameter int SEVEN_SEGMENT_COUNT = 8,
    parameter int DATA_WIDTH          = 16
) (
    input  logic                                  in_clk,
    input  logic                                  in_rst,
    input  logic                                  in_start,
    input  logic                                  in_hex,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic [SEVEN_SEGMENT_COUNT*DIGIT_W-1:0] out_value,
    output logic [SEVEN_SEGMENT_COUNT-1:0]        out_mask,
    output logic                                  out_busy,
    output logic                                  out_done,
    output logic                                  out_overflow
);

    localparam int N     = SEVEN_SEGMENT_COUNT;
    localparam int W     = DATA_WIDTH;
    localparam int VW    = N * DIGIT_W;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [N-1:0] MASK_ONES = '1;
`ifdef BCD_DISPLAY_FORMATTER_LEADING_ZERO_BLANK_EN
    // Idle display shows a single "0" in digit 0.
    localparam logic [N-1:0] MASK_RST = MASK_ONES << 1;
`else
    localparam logic [N-1:0] MASK_RST = '0;
`endif

    // The binary value must fit in the digit vector for hex passthrough.
    if (W < 1 || W > VW) begin : g_bad_width
        $fatal(1, "bcd_display_formatter: DATA_WIDTH must be in 1..4*SEVEN_SEGMENT_COUNT");
    end

`ifdef BCD_DISPLAY_FORMATTER_LEADING_ZERO_BLANK_EN
    // Blank every digit above the most significant nonzero one; digit 0 stays lit.
    function automatic logic [N-1:0] lz_mask(input logic [VW-1:0] v);
        logic seen;
        seen    = 1'b0;
        lz_mask = '0;
        for (int i = N - 1; i >= 1; i--) begin
            if (v[i*DIGIT_W +: DIGIT_W] != '0) begin
                seen = 1'b1;
            end
            lz_mask[i] = ~seen;
        end
    endfunction
`endif

    state_e         state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic [W-1:0]   shift_q,  shift_d;
    logic [VW-1:0]  bcd_q,    bcd_d;
    logic           sticky_q, sticky_d;
    logic           hex_q,    hex_d;
    logic [VW-1:0]  value_q,  value_d;
    logic [N-1:0]   mask_q,   mask_d;
    logic           done_q,   done_d;
    logic           ovf_q,    ovf_d;

    logic [VW-1:0]  step_bcd;
    logic [W-1:0]   step_shift;
    logic           step_carry;
    logic [VW-1:0]  hex_ext;

    bcd_dabble_step #(
        .DIGITS (N),
        .DATA_W (W)
    ) u_step (
        .bcd_in    (bcd_q),
        .shift_in  (shift_q),
        .bcd_out   (step_bcd),
        .shift_out (step_shift),
        .carry_out (step_carry)
    );

    // Hex result is the captured value zero-extended to the digit vector.
    always_comb begin
        hex_ext         = '0;
        hex_ext[W-1:0]  = shift_q;
    end

    // Sequencer next-state and datapath/output register loads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        bcd_d    = bcd_q;
        sticky_d = sticky_q;
        hex_d    = hex_q;
        value_d  = value_q;
        mask_d   = mask_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_start) begin
                    shift_d  = in_data;
                    bcd_d    = '0;
                    sticky_d = 1'b0;
                    hex_d    = in_hex;
                    cnt_d    = CNT_W'(W);
                    if (in_hex) begin
                        state_d = COMMIT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                shift_d  = step_shift;
                bcd_d    = step_bcd;
                sticky_d = sticky_q | step_carry;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = COMMIT;
                    done_d  = 1'b1;
                end
            end

            COMMIT: begin
                state_d = IDLE;
                if (hex_q) begin
                    value_d = hex_ext;
                    ovf_d   = 1'b0;
`ifdef BCD_DISPLAY_FORMATTER_LEADING_ZERO_BLANK_EN
                    mask_d  = lz_mask(hex_ext);
`else
                    mask_d  = '0;
`endif
                end else if (sticky_q) begin
                    value_d = {N{OVF_FILL}};
                    mask_d  = '0;
                    ovf_d   = 1'b1;
                end else begin
                    value_d = bcd_q;
                    ovf_d   = 1'b0;
`ifdef BCD_DISPLAY_FORMATTER_LEADING_ZERO_BLANK_EN
                    mask_d  = lz_mask(bcd_q);
`else
                    mask_d  = '0;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            hex_q    <= 1'b0;
            value_q  <= '0;
            mask_q   <= MASK_RST;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            bcd_q    <= bcd_d;
            sticky_q <= sticky_d;
            hex_q    <= hex_d;
            value_q  <= value_d;
            mask_q   <= mask_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // out_done is high for the cycle the sequencer sits in COMMIT, so it is
    // asserted at the commit edge itself.
    assign out_value    = value_q;
    assign out_mask     = mask_q;
    assign out_busy     = (state_q != IDLE);
    assign out_done     = done_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Self-checking bench: an 8-digit and a 4-digit formatter share the same
// stimulus; a reference model derived from decimal arithmetic predicts every
// output on every cycle, and directed literal checks pin the model.
module tb_bcd_display_formatter;

    localparam int W = 16;

`ifdef BCD_DISPLAY_FORMATTER_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        hex   = 1'b0;
    logic [15:0] data  = '0;

    logic [31:0] v8;
    logic [7:0]  mk8;
    logic        b8, d8, o8;
    logic [15:0] v4;
    logic [3:0]  mk4;
    logic        b4, d4, o4;

    always #5 clk = ~clk;

    bcd_display_formatter #(.SEVEN_SEGMENT_COUNT(8), .DATA_WIDTH(W)) dut8 (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_hex(hex), .in_data(data),
        .out_value(v8), .out_mask(mk8), .out_busy(b8), .out_done(d8), .out_overflow(o8)
    );

    bcd_display_formatter #(.SEVEN_SEGMENT_COUNT(4), .DATA_WIDTH(W)) dut4 (
        .in_clk(clk), .in_rst(rst), .in_start(start), .in_hex(hex), .in_data(data),
        .out_value(v4), .out_mask(mk4), .out_busy(b4), .out_done(d4), .out_overflow(o4)
    );

    int edge_n = 0;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_n);
    endtask

    // ---------------- reference model ----------------
    function automatic longint unsigned p10(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] lz(input logic [31:0] v, input int n);
        logic [31:0] m = '0;
        if (LZB) begin
            for (int i = 1; i < n; i++) m[i] = ((v >> (4 * i)) == 32'd0);
        end
        return m;
    endfunction

    function automatic void calc(input logic [15:0] d, input bit hx, input int n,
                                 output logic [31:0] v, output logic [31:0] m, output bit o);
        longint unsigned x = longint'(d);
        v = '0;
        o = 1'b0;
        if (hx) begin
            v = 32'(d);
        end else if (x < p10(n)) begin
            for (int i = 0; i < n; i++) begin
                v[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end else begin
            for (int i = 0; i < n; i++) v[4*i +: 4] = 4'hF;
            o = 1'b1;
        end
        m = o ? 32'd0 : lz(v, n);
    endfunction

    localparam logic [31:0] RM8 = LZB ? 32'hFE : 32'h0;
    localparam logic [31:0] RM4 = LZB ? 32'hE  : 32'h0;

    bit          m_act = 1'b0;
    int          m_k = 0, m_commit = 0;
    logic [31:0] m_v8 = '0, m_v4 = '0, m_m8 = '0, m_m4 = '0;
    logic [31:0] p_v8, p_v4, p_m8, p_m4;
    bit          m_o8 = 1'b0, m_o4 = 1'b0, p_o8, p_o4;
    int          busy_cnt = 0;
    int          done_at  = -1;

    // Model update at each edge, then compare every output one step later.
    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_act = 1'b0;
            m_v8 = '0; m_v4 = '0; m_m8 = RM8; m_m4 = RM4; m_o8 = 1'b0; m_o4 = 1'b0;
        end else if (m_act) begin
            if (edge_n == m_commit) begin
                m_act = 1'b0;
                m_v8 = p_v8; m_m8 = p_m8; m_o8 = p_o8;
                m_v4 = p_v4; m_m4 = p_m4; m_o4 = p_o4;
            end
        end else if (start) begin
            m_act    = 1'b1;
            m_k      = edge_n;
            m_commit = edge_n + (hex ? 1 : W + 1);
            busy_cnt = 0;
            calc(data, hex, 8, p_v8, p_m8, p_o8);
            calc(data, hex, 4, p_v4, p_m4, p_o4);
        end
        #1;
        if (b8) busy_cnt++;
        if (d8) done_at = edge_n + 1;
        chk("busy8",  64'(b8),  64'(m_act));
        chk("done8",  64'(d8),  64'(m_act && (edge_n == m_commit - 1)));
        chk("value8", 64'(v8),  64'(m_v8));
        chk("mask8",  64'(mk8), 64'(m_m8));
        chk("ovf8",   64'(o8),  64'(m_o8));
        chk("busy4",  64'(b4),  64'(m_act));
        chk("done4",  64'(d4),  64'(m_act && (edge_n == m_commit - 1)));
        chk("value4", 64'(v4),  64'(m_v4));
        chk("mask4",  64'(mk4), 64'(m_m4));
        chk("ovf4",   64'(o4),  64'(m_o4));
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse(input int unsigned d, input bit hx);
        start = 1'b1;
        data  = 16'(d);
        hex   = hx;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_value", 64'(v8),  64'd0);
        chk("rst_busy",  64'(b8),  64'd0);
        chk("rst_mask",  64'(mk8), LZB ? 64'hFE : 64'h00);

        // Decimal 12345
        pulse(12345, 1'b0);
        repeat (20) @(negedge clk);
        chk("d12345_val",   64'(v8),  64'h00012345);
        chk("d12345_ovf",   64'(o8),  64'd0);
        chk("d12345_mask",  64'(mk8), LZB ? 64'hE0 : 64'h00);
        chk("d12345_lat",   64'(done_at - m_k), 64'd17);
        chk("d12345_busy",  64'(busy_cnt), 64'd17);

        // Decimal 0
        pulse(0, 1'b0);
        repeat (20) @(negedge clk);
        chk("d0_val",  64'(v8),  64'h0);
        chk("d0_mask", 64'(mk8), LZB ? 64'hFE : 64'h00);

        // Decimal 65535: fits 8 digits, overflows 4
        pulse(65535, 1'b0);
        repeat (20) @(negedge clk);
        chk("d65535_val",   64'(v8),  64'h00065535);
        chk("d65535_mask",  64'(mk8), LZB ? 64'hE0 : 64'h00);
        chk("d65535_v4",    64'(v4),  64'hFFFF);
        chk("d65535_o4",    64'(o4),  64'd1);
        chk("d65535_m4",    64'(mk4), 64'h0);

        // Overflow on 4 digits, then cleared by 42
        pulse(12345, 1'b0);
        repeat (20) @(negedge clk);
        chk("ovf_v4", 64'(v4), 64'hFFFF);
        chk("ovf_o4", 64'(o4), 64'd1);
        pulse(42, 1'b0);
        repeat (20) @(negedge clk);
        chk("d42_o4", 64'(o4), 64'd0);
        chk("d42_v4", 64'(v4), 64'h0042);

        // Hex passthrough
        pulse(16'hBEEF, 1'b1);
        repeat (4) @(negedge clk);
        chk("hex_val",  64'(v8),  64'h0000BEEF);
        chk("hex_mask", 64'(mk8), LZB ? 64'hF0 : 64'h00);
        chk("hex_ovf",  64'(o8),  64'd0);
        chk("hex_lat",  64'(done_at - m_k), 64'd1);
        chk("hex_v4",   64'(v4),  64'hBEEF);

        // Re-pulse at k+5 and during the done cycle are both ignored
        pulse(1000, 1'b0);
        repeat (4) @(negedge clk);
        pulse(999, 1'b0);
        repeat (11) @(negedge clk);
        pulse(7777, 1'b0);
        chk("repulse_busy", 64'(b8), 64'd0);
        chk("repulse_val",  64'(v8), 64'h00001000);
        chk("repulse_lat",  64'(done_at - m_k), 64'd17);
        repeat (5) @(negedge clk);
        chk("repulse_idle", 64'(b8), 64'd0);

        // Reset at k+8 mid-conversion
        done_at = -1;
        pulse(5555, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(b8),  64'd0);
        chk("midrst_val",  64'(v8),  64'd0);
        chk("midrst_mask", 64'(mk8), LZB ? 64'hFE : 64'h00);
        repeat (20) @(negedge clk);
        chk("midrst_nodone", 64'(done_at), 64'hFFFF_FFFF_FFFF_FFFF);

        // Fresh conversion after reset
        pulse(321, 1'b0);
        repeat (20) @(negedge clk);
        chk("post_val", 64'(v8), 64'h00000321);
        chk("post_v4",  64'(v4), 64'h0321);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bcd_display_formatter.md
Name: bcd_display_formatter

Overview:
- Upstream feeder for the seven-segment display controller. Converts a binary value into the per-digit nibble vector and blanking mask that controller consumes.
- Decimal mode uses a sequential double-dabble (shift-and-add-3) engine, one bit per clock. Hex mode passes the value through.
- Outputs are registered and change only on a commit edge, so the multiplexed display never shows partial results.

Parameters:
- SEVEN_SEGMENT_COUNT, 8, number of display digits N; out_value is 4*N bits.
- DATA_WIDTH, 16, binary input width W; constraint 1 <= W <= 4*N (elaboration-time check, fatal if violated).

Ports:
- in_clk  input  1  system clock; single clock domain.
- in_rst  input  1  synchronous reset, active-high.
- in_start  input  1  one-cycle request; samples in_data and in_hex; ignored while out_busy=1.
- in_hex  input  1  1 = hex passthrough, 0 = decimal conversion.
- in_data  input  W  unsigned binary value.
- out_value  output  4*N  digit nibbles; digit i at [4i+3:4i], digit 0 is least significant.
- out_mask  output  N  1 = blank digit i; ORed into the active-low anodes downstream.
- out_busy  output  1  conversion in progress.
- out_done  output  1  one-cycle pulse on the commit edge.
- out_overflow  output  1  last committed decimal result did not fit in N digits; held until the next commit.

Behaviour:
- Reset (synchronous, any state, including mid-conversion): state IDLE, shift/BCD registers 0, out_value 0, out_busy 0, out_done 0, out_overflow 0.
  - out_mask resets to {N-1 ones, 0} with the optional feature enabled, otherwise to all-zero.
  - Any conversion in flight is discarded.
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - in_start=1 at edge k captures in_data into the shift register, clears the BCD accumulator and the overflow sticky, and latches in_hex.
  - Next state is SHIFT with bit counter W, or COMMIT directly when in_hex=1.
- SHIFT, one double-dabble step per edge (k+1 .. k+W):
  - Every BCD digit >= 5 gets +3.
  - The {BCD, shift} register is then shifted left by 1.
  - The bit shifted out of the top digit's MSB ORs into the overflow sticky.
  - After W steps, go to COMMIT.
- COMMIT edge (k+W+1 decimal, k+1 hex):
  - out_value loads the BCD accumulator (hex: in_data zero-extended to 4*N).
  - out_overflow loads the sticky; it is always 0 in hex mode.
  - out_mask is updated and out_done=1 for exactly this cycle. Next state is IDLE.
- Overflow result: out_value forced to all 4'hF, out_mask all-zero, out_overflow=1.
- out_busy is 1 in SHIFT and COMMIT and 0 in IDLE. It rises after edge k and falls after the commit edge.
- Earliest re-accept: in_start on the cycle after out_done.
- Back-to-back: in_start asserted during out_done is ignored, because the FSM is still in COMMIT.
- Outputs hold their last committed value indefinitely between conversions.
- Arithmetic: digit add-3 is 4-bit with no carry between digits. The bit counter is $clog2(W+1) wide.

Optional Feature:
- Macro: BCD_DISPLAY_FORMATTER_LEADING_ZERO_BLANK_EN.
- Defined: at commit, out_mask[i]=1 for every digit i above the most significant nonzero digit. Digit 0 is never blanked, so the value 0 shows a single "0". This applies in both hex and decimal modes; an overflow result is never blanked.
- Undefined: out_mask is constant all-zero and all N digits are lit, including leading zeros.

Decomposition:
- Shared package seven_seg_pkg holds:
  - digit nibble width constant (4);
  - add-3 threshold constant (5);
  - FSM state typedef (IDLE/SHIFT/COMMIT);
  - overflow fill constant (4'hF).
- One natural sub-module: bcd_dabble_step. It is combinational, N-digit add-3 then shift by one, with carry-out used for overflow.
- The FSM, counter and output registers stay in the top module.

Test Plan:
- Decimal 12345 (W=16, N=8), start at edge k:
  - out_busy=1 for 17 cycles; out_done at edge k+17;
  - out_value=32'h00012345, out_overflow=0;
  - out_mask=8'b11100000 with the macro, 8'h00 without.
- Decimal 0: out_value=32'h00000000; out_mask=8'b11111110 with the macro; 65535 gives out_value=32'h00065535, out_mask=8'b11100000.
- Overflow, N=4, W=16, value 12345: out_value=16'hFFFF, out_mask=4'b0000, out_overflow=1; a following conversion of 42 clears out_overflow to 0.
- Hex 16'hBEEF: out_done at edge k+1; out_value=32'h0000BEEF, out_mask=8'b11110000 with the macro, out_overflow=0.
- in_start re-pulsed with a different in_data at k+5 during a decimal conversion: ignored, and the original result commits at k+17. in_start during the out_done cycle is also ignored.
- in_rst asserted at k+8 mid-conversion: next cycle out_busy=0, out_value=0, no out_done pulse; a fresh start after reset converts correctly.
